load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
//
// PURPOSE
// Sits between the core's memory stage and the shared I/O bus (addr/data/rw/size)
// that the memory-mapped I/O controller decodes. Accepts one load or store at a
// time over a valid/ready handshake and checks alignment. Runs the bus cycle with
// the timing the bus devices expect. Returns sign/zero-extended load data or a
// fault on a one-cycle response strobe.
//
// PARAMETERS
// BUS_READ_CYCLES  2  cycles addr/size/rw held for a read; data sampled at last edge (>=2)
// CHECK_ALIGN      1  1: misaligned half/word requests fault without a bus cycle; 0: pass through
//
// PORTS
// clk           in     1   clock, all state updates on posedge
// rst_n         in     1   asynchronous, active-low reset
// req_valid     in     1   core presents a request
// req_ready     out    1   unit can accept; high only in IDLE
// req_write     in     1   1 = store, 0 = load
// req_size      in     2   00 none, 01 byte, 10 half, 11 word
// req_unsigned  in     1   loads: 1 zero-extend, 0 sign-extend
// req_addr      in     32  byte address
// req_wdata     in     32  store data, right-justified
// rsp_valid     out    1   one-cycle response strobe
// rsp_rdata     out    32  extended load data (0 for stores/faults)
// rsp_fault     out    1   request rejected (size 00 or misaligned)
// addr          out    32  bus address
// data          inout  32  bus data, right-justified; driven only during store cycles
// rw            out    1   bus direction, 1 = write
// size          out    2   bus size, same encoding as req_size; 00 = bus idle
//
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; req_ready=1, rsp_valid=0, rsp_fault=0, rsp_rdata=0,
//   addr=0, rw=0, size=00, data=Z. Takes effect immediately. An in-flight access is
//   abandoned and produces no response.
// - States: IDLE, WRITE, READ, RESP. Request fields are latched on the posedge with
//   req_valid&&req_ready. Inputs are ignored outside IDLE.
// - IDLE: bus idle (size=00, rw=0, addr=0, data=Z). On accept:
//   size 00 -> RESP, fault=1.
//   half with addr[0]!=0, or word with addr[1:0]!=0 (CHECK_ALIGN=1) -> RESP, fault=1.
//   Otherwise -> WRITE if req_write, else READ.
// - WRITE (1 cycle): addr=latched, size=latched, rw=1, data driven.
//   Byte: {24'b0,w[7:0]}. Half: {16'b0,w[15:0]}. Word: w. Next state RESP.
// - READ: addr/size driven, rw=0, data=Z, held for exactly BUS_READ_CYCLES cycles via a
//   down-counter. data is captured on the posedge that ends the last cycle, then extended.
//   Byte uses data[7:0] with sign bit 7. Half uses data[15:0] with sign bit 15.
//   Word passes through. req_unsigned=1 zero-extends. Next state RESP.
// - RESP (1 cycle): rsp_valid=1 with rsp_rdata/rsp_fault valid; bus idle; req_ready=0. Next state IDLE.
//   rsp_rdata/rsp_fault hold their value until the next RESP or reset.
// - Latency (accept edge = E0): store rsp_valid in cycle after E1. Fault rsp_valid in cycle
//   after E0. Load rsp_valid in cycle after E(BUS_READ_CYCLES).
//   Back-to-back: next accept no earlier than the edge ending RESP+1 IDLE cycle.
// - The bus never carries size!=00 outside WRITE/READ. Address is never decoded here;
//   unmapped addresses read whatever floats on data (bench pulls data to 0).
//
// TESTING
// 1 Reset: rst_n=0 mid-READ -> size=00, data=Z, rsp_valid stays 0, req_ready=1 after release.
// 2 Store byte addr=8000_0000 wdata=DEAD_BEEF -> 1 cycle rw=1 size=01 data=0000_00EF;
//   rsp_valid 2 cycles after accept, fault=0.
// 3 Load byte signed, bus returns 0000_0380 -> rsp_rdata=FFFF_FF80. Same with unsigned ->
//   0000_0080. Size held exactly 2 cycles.
// 4 Load half addr=8000_0002, bus returns 0000_03FF -> rsp_rdata=0000_03FF (bit15=0, signed).
// 5 Word load addr=8000_0001, and size=00 request -> rsp_fault=1 one cycle after accept,
//   bus size stays 00.
// 6 Back-to-back store then load with req_valid held high -> second accept only after
//   RESP; no bus overlap.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time over valid/ready, alignment check,
// timed bus cycle on the shared addr/data/rw/size bus, extended load response.
module load_store_unit #(
   parameter int BUS_READ_CYCLES = 2,
   parameter bit CHECK_ALIGN     = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic [31:0] addr,
   inout  wire  [31:0] data,
   output logic        rw,
   output logic [1:0]  size
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   localparam int CW = $clog2(BUS_READ_CYCLES + 1);

   state_t      state;
   logic [CW-1:0] cnt;
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic        data_oe;
   logic [31:0] wdata_q;
   logic        reject;
   logic [31:0] wdata_fit;

   // Size 00 is always rejected; alignment is only enforced when CHECK_ALIGN is set.
   always_comb begin
      reject = (req_size == 2'b00);
      if (CHECK_ALIGN) begin
         if (req_size == 2'b10 && req_addr[0])         reject = 1'b1;
         if (req_size == 2'b11 && req_addr[1:0] != 2'b00) reject = 1'b1;
      end
   end

   // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
   always_comb begin
      case (req_size)
         2'b01:   wdata_fit = {24'b0, req_wdata[7:0]};
         2'b10:   wdata_fit = {16'b0, req_wdata[15:0]};
         default: wdata_fit = req_wdata;
      endcase
   end

   function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                          input logic uns);
      case (sz)
         2'b01:   return uns ? {24'b0, d[7:0]}  : {{24{d[7]}},  d[7:0]};
         2'b10:   return uns ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
         default: return d;
      endcase
   endfunction

   // The bus data lines are released whenever this unit is not in a store cycle.
   assign data = data_oe ? wdata_q : {32{1'bz}};

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         data_oe    <= 1'b0;
         wdata_q    <= 32'h0;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 32'h0;
         rsp_fault  <= 1'b0;
         addr       <= 32'h0;
         rw         <= 1'b0;
         size       <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready  <= 1'b0;
                  size_q     <= req_size;
                  unsigned_q <= req_unsigned;
                  if (reject) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_fault <= 1'b1;
                     rsp_rdata <= 32'h0;
                  end else if (req_write) begin
                     state   <= WRITE;
                     addr    <= req_addr;
                     size    <= req_size;
                     rw      <= 1'b1;
                     data_oe <= 1'b1;
                     wdata_q <= wdata_fit;
                  end else begin
                     state <= READ;
                     addr  <= req_addr;
                     size  <= req_size;
                     rw    <= 1'b0;
                     cnt   <= CW'(BUS_READ_CYCLES - 1);
                  end
               end
            end
            WRITE: begin
               state     <= RESP;
               addr      <= 32'h0;
               size      <= 2'b00;
               rw        <= 1'b0;
               data_oe   <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_fault <= 1'b0;
               rsp_rdata <= 32'h0;
            end
            READ: begin
               if (cnt == '0) begin
                  state     <= RESP;
                  addr      <= 32'h0;
                  size      <= 2'b00;
                  rsp_valid <= 1'b1;
                  rsp_fault <= 1'b0;
                  rsp_rdata <= extend(data, size_q, unsigned_q);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests, a transaction-level model checked
// every cycle, and literal expectations on each directed request.
module tb_load_store_unit;

   localparam int N = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic [31:0] addr;
   wire  [31:0] data;
   logic        rw;
   logic [1:0]  size;
   logic [31:0] dev_rdata = 32'h0;

   always #5 clk = ~clk;

   load_store_unit #(.BUS_READ_CYCLES(N), .CHECK_ALIGN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_fault(rsp_fault), .addr(addr), .data(data), .rw(rw), .size(size)
   );

   // Bus device: answers reads, otherwise pulls the lines to 0; releases them for writes.
   assign data = rw ? {32{1'bz}} : ((size != 2'b00) ? dev_rdata : 32'h0);

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      bit        wr;
      bit [1:0]  sz;
      bit        uns;
      bit [31:0] a;
      bit [31:0] wd;
      bit [31:0] dev;
      int        acc;
   } txn_t;

   txn_t q[$];
   int   cyc = 0;
   int   n_acc = 0;
   int   acc_hist[$];

   function automatic bit model_fault(input txn_t t);
      return (t.sz == 2'd0) || (t.sz == 2'd2 && t.a % 2 != 0) || (t.sz == 2'd3 && t.a % 4 != 0);
   endfunction

   function automatic longint unsigned span(input bit [1:0] sz);
      int nbytes;
      nbytes = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
      return 64'd1 << (8 * nbytes);
   endfunction

   function automatic logic [31:0] model_wdata(input txn_t t);
      return 32'(longint'(t.wd) % span(t.sz));
   endfunction

   function automatic logic [31:0] model_rdata(input txn_t t);
      longint unsigned v;
      if (model_fault(t) || t.wr) return 32'h0;
      v = longint'(t.dev) % span(t.sz);
      if (!t.uns && t.sz != 2'd3 && v >= span(t.sz) / 2) v = v + (64'd1 << 32) - span(t.sz);
      return 32'(v);
   endfunction

   function automatic int resp_at(input txn_t t);
      if (model_fault(t)) return t.acc;
      if (t.wr) return t.acc + 1;
      return t.acc + N;
   endfunction

   // Accept monitor: records every handshake as a model transaction.
   always @(posedge clk) begin
      txn_t t;
      cyc++;
      if (rst_n && req_valid && req_ready) begin
         t.wr  = req_write;
         t.sz  = req_size;
         t.uns = req_unsigned;
         t.a   = req_addr;
         t.wd  = req_wdata;
         t.dev = dev_rdata;
         t.acc = cyc;
         q.push_back(t);
         n_acc++;
         acc_hist.push_back(cyc);
      end
   end

   always @(negedge rst_n) q.delete();

   // Cycle compare against the model.
   always @(negedge clk) begin
      txn_t        h;
      bit          exp_v;
      bit          drive;
      logic [31:0] ea, ed;
      logic [1:0]  es;
      logic        erw;
      exp_v = 1'b0; drive = 1'b0; ea = 32'h0; ed = 32'h0; es = 2'b00; erw = 1'b0;
      if (q.size() > 0) begin
         h = q[0];
         if (!model_fault(h) && cyc >= h.acc && cyc < resp_at(h)) begin
            ea = h.a; es = h.sz; erw = h.wr;
            if (h.wr) begin
               drive = 1'b1;
               ed = model_wdata(h);
            end
         end
         exp_v = (cyc == resp_at(h));
      end
      check("cyc req_ready", 32'(req_ready), 32'(q.size() == 0));
      check("cyc rsp_valid", 32'(rsp_valid), 32'(exp_v));
      check("cyc bus addr", addr, ea);
      check("cyc bus size", 32'(size), 32'(es));
      check("cyc bus rw", 32'(rw), 32'(erw));
      if (drive) check("cyc bus data", data, ed);
      if (exp_v) begin
         check("cyc rsp_rdata", rsp_rdata, model_rdata(h));
         check("cyc rsp_fault", 32'(rsp_fault), 32'(model_fault(h)));
         void'(q.pop_front());
      end
   end

   task automatic wait_ready(input string nm);
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      if (!req_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: req_ready never rose", nm);
      end
   endtask

   task automatic run(input string nm, input bit wr, input bit [1:0] sz, input bit uns,
                      input bit [31:0] a, input bit [31:0] wd, input bit [31:0] dev,
                      input bit [31:0] exp_rdata, input bit exp_fault, input int exp_bus,
                      input bit [31:0] exp_data);
      int          nb;
      bit          got;
      logic [31:0] bd;
      nb = 0; got = 1'b0; bd = 32'h0;
      @(negedge clk);
      wait_ready(nm);
      req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
      dev_rdata = dev; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (size != 2'b00) begin
            nb++;
            if (rw) bd = data;
         end
         if (rsp_valid) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: no rsp_valid within 20 cycles", nm);
      end else begin
         check({nm, " rdata"}, rsp_rdata, exp_rdata);
         check({nm, " fault"}, 32'(rsp_fault), 32'(exp_fault));
         check({nm, " bus cycles"}, 32'(nb), 32'(exp_bus));
         if (wr && exp_bus > 0) check({nm, " bus data"}, bd, exp_data);
      end
   endtask

   initial begin
      int a0;
      #1 rst_n = 1'b0;
      #1;
      check("reset req_ready", 32'(req_ready), 32'd1);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset size", 32'(size), 32'd0);
      check("reset rsp_rdata", rsp_rdata, 32'h0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      // Reset in the middle of a read abandons it silently.
      @(negedge clk);
      req_write = 1'b0; req_size = 2'b01; req_unsigned = 1'b0; req_addr = 32'h8000_0020;
      dev_rdata = 32'h0000_0055; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check("midread size", 32'(size), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst size", 32'(size), 32'd0);
      check("rst rw", 32'(rw), 32'd0);
      check("rst data released", data, 32'h0);
      check("rst req_ready", 32'(req_ready), 32'd1);
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      repeat (2) begin
         @(negedge clk);
         check("rst hold rsp_valid", 32'(rsp_valid), 32'd0);
      end
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post-rst req_ready", 32'(req_ready), 32'd1);
      check("post-rst rsp_valid", 32'(rsp_valid), 32'd0);

      //  name                 wr sz     uns addr           wdata          dev            rdata          flt bus data
      run("st byte",          1, 2'b01, 0, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0,         32'h0,         0,  1,  32'h0000_00EF);
      run("ld byte s",        0, 2'b01, 0, 32'h8000_0000, 32'h0,         32'h0000_0380, 32'hFFFF_FF80, 0,  N,  32'h0);
      run("ld byte u",        0, 2'b01, 1, 32'h8000_0000, 32'h0,         32'h0000_0380, 32'h0000_0080, 0,  N,  32'h0);
      run("ld half pos",      0, 2'b10, 0, 32'h8000_0002, 32'h0,         32'h0000_03FF, 32'h0000_03FF, 0,  N,  32'h0);
      run("ld half neg",      0, 2'b10, 0, 32'h8000_0002, 32'h0,         32'h0001_8001, 32'hFFFF_8001, 0,  N,  32'h0);
      run("ld half u",        0, 2'b10, 1, 32'h8000_0006, 32'h0,         32'hFFFF_8001, 32'h0000_8001, 0,  N,  32'h0);
      run("ld word",          0, 2'b11, 0, 32'h8000_0004, 32'h0,         32'h8765_4321, 32'h8765_4321, 0,  N,  32'h0);
      run("ld byte odd",      0, 2'b01, 0, 32'h8000_0003, 32'h0,         32'h0000_007F, 32'h0000_007F, 0,  N,  32'h0);
      run("st half",          1, 2'b10, 0, 32'h8000_0002, 32'hCAFE_1234, 32'h0,         32'h0,         0,  1,  32'h0000_1234);
      run("st word",          1, 2'b11, 0, 32'h8000_0004, 32'hA5A5_5A5A, 32'h0,         32'h0,         0,  1,  32'hA5A5_5A5A);
      run("ld word misalign", 0, 2'b11, 0, 32'h8000_0001, 32'h0,         32'h1111_1111, 32'h0,         1,  0,  32'h0);
      run("ld size none",     0, 2'b00, 0, 32'h8000_0000, 32'h0,         32'h1111_1111, 32'h0,         1,  0,  32'h0);
      run("st half misalign", 1, 2'b10, 0, 32'h8000_0003, 32'h1234_5678, 32'h0,         32'h0,         1,  0,  32'h0);
      run("ld word off2",     0, 2'b11, 1, 32'h8000_0002, 32'h0,         32'h2222_2222, 32'h0,         1,  0,  32'h0);

      // Back-to-back with req_valid held: second accept waits for RESP plus one idle cycle.
      @(negedge clk);
      wait_ready("b2b");
      a0 = n_acc;
      req_write = 1'b1; req_size = 2'b11; req_unsigned = 1'b0; req_addr = 32'h8000_0010;
      req_wdata = 32'h1111_2222; req_valid = 1'b1;
      @(negedge clk);
      req_write = 1'b0; req_size = 2'b01; req_addr = 32'h8000_0011; dev_rdata = 32'h0000_00F0;
      for (int i = 0; i < 20 && n_acc < a0 + 2; i++) @(negedge clk);
      req_valid = 1'b0;
      check("b2b accepts", 32'(n_acc - a0), 32'd2);
      if (n_acc >= a0 + 2)
         check("b2b accept spacing", 32'(acc_hist[n_acc - 1] - acc_hist[n_acc - 2]), 32'd3);
      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      check("b2b drained", 32'(q.size()), 32'd0);
      check("b2b load rdata", rsp_rdata, 32'hFFFF_FFF0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
